// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   WIDTH-bit adder/subtractor built as a chain of clocked one-bit slices.
//   Slice k resolves bit k one cycle after slice k-1, and the carry is
//   registered between slices. Every stage has its own valid bit, so one
//   full-width word is accepted and one is emitted per clock.
//   Latency is WIDTH + OUT_REG cycles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          operand word present (no backpressure)
//   sub, cin          0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b              operands
//   out_valid         result word present
//   sum, cout, ovf    result, MSB carry-out (no-borrow on sub), signed overflow
//   busy              any pipeline stage holds a valid token
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH   = 8,
    parameter bit          OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    // Operand registers exist only between slices (the last slice consumes
    // its bits directly), hence WIDTH-1 of them.
    localparam int unsigned OPS = (WIDTH > 1) ? WIDTH - 1 : 1;

    // Each stage carries a whole word. Operand bits already consumed and
    // result bits not yet produced are never read, so what remains after
    // optimisation is the input-skew and output-deskew triangles.
    logic [WIDTH-1:0] a_q [OPS];
    logic [WIDTH-1:0] a_d [OPS];
    logic [WIDTH-1:0] b_q [OPS];
    logic [WIDTH-1:0] b_d [OPS];
    logic [WIDTH-1:0] s_q [WIDTH];
    logic [WIDTH-1:0] s_d [WIDTH];
    logic [WIDTH-1:0] c_q, c_d;       // carry out of slice k
    logic [WIDTH-1:0] v_q, v_d;       // token valid at slice k
    logic             ovf_q, ovf_d;

    // Inputs seen by each slice: entry ports for slice 0, previous stage otherwise.
    logic [WIDTH-1:0] a_in [WIDTH];
    logic [WIDTH-1:0] b_in [WIDTH];
    logic [WIDTH-1:0] s_in [WIDTH];
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] v_in;

    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    always_comb begin
        a_in[0] = a;
        b_in[0] = b_eff;
        s_in[0] = '0;
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int unsigned j = 1; j < WIDTH; j++) begin
            a_in[j] = a_q[j-1];
            b_in[j] = b_q[j-1];
            s_in[j] = s_q[j-1];
            c_in[j] = c_q[j-1];
            v_in[j] = v_q[j-1];
        end
    end

    // Stage registers only load on a valid token, so empty slots leave the
    // last result standing at the tail.
    always_comb begin
        for (int unsigned k = 0; k < OPS; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
        end
        c_d   = c_q;
        v_d   = v_in;
        ovf_d = ovf_q;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            s_d[j] = s_q[j];
            if (v_in[j]) begin
                s_d[j]    = s_in[j];
                s_d[j][j] = a_in[j][j] ^ b_in[j][j] ^ c_in[j];
                c_d[j]    = (a_in[j][j] & b_in[j][j]) |
                            (a_in[j][j] & c_in[j])    |
                            (b_in[j][j] & c_in[j]);
                if (j < WIDTH - 1) begin
                    a_d[j] = a_in[j];
                    b_d[j] = b_in[j];
                end
            end
        end
        if (v_in[WIDTH-1]) begin
            ovf_d = c_in[WIDTH-1] ^ c_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < OPS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int unsigned j = 0; j < WIDTH; j++) begin
                s_q[j] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < OPS; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            for (int unsigned j = 0; j < WIDTH; j++) begin
                s_q[j] <= s_d[j];
            end
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [WIDTH-1:0] res_q, res_d;
            logic             co_q, co_d;
            logic             of_q, of_d;
            logic             ov_q, ov_d;

            always_comb begin
                ov_d  = v_q[WIDTH-1];
                res_d = res_q;
                co_d  = co_q;
                of_d  = of_q;
                if (v_q[WIDTH-1]) begin
                    res_d = s_q[WIDTH-1];
                    co_d  = c_q[WIDTH-1];
                    of_d  = ovf_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                    co_q  <= 1'b0;
                    of_q  <= 1'b0;
                    ov_q  <= 1'b0;
                end else begin
                    res_q <= res_d;
                    co_q  <= co_d;
                    of_q  <= of_d;
                    ov_q  <= ov_d;
                end
            end

            assign out_valid = ov_q;
            assign sum       = res_q;
            assign cout      = co_q;
            assign ovf       = of_q;
            assign busy      = (|v_q) | ov_q;
        end else begin : g_nooreg
            assign out_valid = v_q[WIDTH-1];
            assign sum       = s_q[WIDTH-1];
            assign cout      = c_q[WIDTH-1];
            assign ovf       = ovf_q;
            assign busy      = |v_q;
        end
    endgenerate

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised successor to the gate-level pipelined one-bit full adder: a WIDTH-bit adder/subtractor built as a chain of bit-slice stages.
- Each slice is clocked, and the carry is registered between slices, matching the per-gate clocking of the SFQ-style cells.
- Operand bits are skewed on entry and result bits deskewed on exit, so one full-width operation is accepted and one emitted per clock.
- Sits in the datapath wherever multi-bit arithmetic is required.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- OUT_REG, 1, 1 adds a final output register stage (+1 cycle latency); 0 drives outputs from the deskew stage.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand word valid this cycle; no backpressure, accepted unconditionally.
- sub  input  1  0 = add, 1 = subtract; sampled with in_valid.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result word valid this cycle.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of MSB slice; for sub, 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high while any pipeline stage holds a valid token.

Behaviour:
- Reset: all skew, slice, carry, deskew and output registers and all valid bits clear to 0 immediately on rst_n low. out_valid=0, sum=0, cout=0, ovf=0, busy=0.
- Operand preparation at entry:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Input skew: bit k of a and b_eff is delayed k cycles, so it reaches slice k together with the carry from slice k-1.
- Slice k, registered each cycle:
  - s_k = a_k ^ b_k ^ c_k.
  - c_{k+1} = majority(a_k, b_k, c_k).
- Slice 0 takes c0, which travels with its token.
- Output deskew: bit k of s is delayed WIDTH-1-k cycles; cout and ovf are aligned with the MSB.
- Latency: word sampled at edge E appears at outputs after edge E+WIDTH-1+OUT_REG+1, i.e. LATENCY = WIDTH+OUT_REG cycles. For WIDTH=8, OUT_REG=1, the result is visible 9 cycles after the input cycle.
- Throughput: one word per cycle. Back-to-back words, including alternating sub, never interfere; each token carries its own carry chain.
- Valid: a valid shift register of length LATENCY tracks tokens. out_valid is the tail. busy = OR of all valid bits, including the tail.
- Gaps: when in_valid=0 the token slot is empty. out_valid=0 in the matching output cycle; sum/cout/ovf hold the last valid result (no update on empty tokens).
- Arithmetic is modulo 2^WIDTH; carries beyond the MSB are reported only via cout.
- Reset mid-operation discards all in-flight tokens. No result emerges after rst_n deasserts unless new in_valid is applied.
- WIDTH=1: degenerates to the registered one-bit full adder, with sum/cout equal to the original cell's truth table and latency 1+OUT_REG.
- No state machine beyond the pipeline; no stall or flush input (reset is the only flush).

Test Plan (WIDTH=8, OUT_REG=1 unless stated):
1. Add 0xFF+0x01, cin=0, single pulse at cycle 0 -> cycle 9: out_valid=1, sum=0x00, cout=1, ovf=0; out_valid=0 in cycles 8 and 10; busy high cycles 1..9.
2. Add 0x7F+0x01, cin=1 -> sum=0x81, cout=0, ovf=1; then sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; then sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
3. Stream of 16 back-to-back random words with random sub/cin -> 16 consecutive out_valid cycles starting at cycle 9. Every result matches the reference model in order; no cross-word carry leakage.
4. Pattern valid,gap,valid,gap,gap,valid -> out_valid reproduces the same pattern shifted by 9 cycles; sum holds the previous value during gaps.
5. Issue 4 words, assert rst_n low for 1 cycle at cycle 5 -> outputs zero immediately; no out_valid in cycles 6..20; busy=0; a new word issued after release returns correctly 9 cycles later.
6. WIDTH=1, OUT_REG=0, all 8 (a,b,cin) combinations back-to-back -> sum/cout match the full-adder truth table, each 1 cycle after input; WIDTH=64 random sweep -> latency 65, results correct.
